// File: rtl/timing_ctrl.sv
// ---------------------------------------------------------------------------
// timing_ctrl
//
// Drives the CPU's T0..T(NPHASE-1) timing ring. The datapath consumes the
// one-hot phase vector T; this block adds run / halt / single-step control,
// early instruction termination from the decoder, memory wait states and a
// completed-instruction counter.
//
// Parameters
//   NPHASE  phases per full instruction cycle (>= 2), T[0] is the first phase
//   CYC_W   width of the instruction counter, wraps modulo 2**CYC_W
//
// Ports
//   clk       in   1       clock, all logic on the rising edge
//   rst       in   1       synchronous active-high reset
//   start     in   1       run request, only looked at while IDLE or HALTED
//   step      in   1       single-instruction request, only while IDLE/HALTED
//   halt      in   1       stop request, taken at the next instruction boundary
//   cyc_end   in   1       decoder says the current phase ends the instruction
//   mem_wait  in   1       memory not ready, freeze the current phase
//   T         out  NPHASE  one-hot phase vector, all-zero when not running
//   running   out  1       state is RUN or STEP
//   halted    out  1       state is HALTED
//   fetch     out  1       running and in T0 or T1
//   icount    out  CYC_W   completed-instruction count
// ---------------------------------------------------------------------------
module timing_ctrl #(
    parameter int NPHASE = 8,
    parameter int CYC_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              step,
    input  logic              halt,
    input  logic              cyc_end,
    input  logic              mem_wait,
    output logic [NPHASE-1:0] T,
    output logic              running,
    output logic              halted,
    output logic              fetch,
    output logic [CYC_W-1:0]  icount
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_RUN    = 2'd1;
    localparam logic [1:0] ST_STEP   = 2'd2;
    localparam logic [1:0] ST_HALTED = 2'd3;

    logic [1:0] state;
    logic       halt_pend;

    // Combinational helpers for the running states. A boundary is either the
    // decoder cutting the instruction short or the ring reaching its last
    // phase; both together still count as one boundary. A halt request seen
    // on the boundary cycle itself stops the machine right away, so it is
    // folded in with the sticky pending flag here.
    logic boundary;
    logic halt_now;
    logic stop_here;

    always_comb begin
        boundary  = cyc_end | T[NPHASE-1];
        halt_now  = (state == ST_RUN) & halt;
        stop_here = (state == ST_STEP) | halt_pend | halt_now;
    end

    // Main sequencer. IDLE and HALTED wait for start/step with T held at
    // zero. RUN and STEP walk the ring, freezing on mem_wait (cyc_end is
    // dropped on those cycles and the decoder has to present it again).
    // Entering HALTED always clears the pending halt, even if halt is still
    // asserted that cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            T         <= '0;
            halt_pend <= 1'b0;
            icount    <= '0;
        end else begin
            case (state)
                ST_IDLE, ST_HALTED: begin
                    if (start) begin
                        state <= ST_RUN;
                        T     <= NPHASE'(1);
                    end else if (step) begin
                        state <= ST_STEP;
                        T     <= NPHASE'(1);
                    end
                end
                ST_RUN, ST_STEP: begin
                    if (halt_now) begin
                        halt_pend <= 1'b1;
                    end
                    if (!mem_wait) begin
                        if (boundary) begin
                            icount <= icount + CYC_W'(1);
                            if (stop_here) begin
                                state     <= ST_HALTED;
                                T         <= '0;
                                halt_pend <= 1'b0;
                            end else begin
                                T <= NPHASE'(1);
                            end
                        end else begin
                            T <= {T[NPHASE-2:0], 1'b0};
                        end
                    end
                end
                default: begin
                    state     <= ST_IDLE;
                    T         <= '0;
                    halt_pend <= 1'b0;
                end
            endcase
        end
    end

    // Status outputs are decoded purely from registered state.
    always_comb begin
        running = (state == ST_RUN) | (state == ST_STEP);
        halted  = (state == ST_HALTED);
        fetch   = running & (T[0] | T[1]);
    end

endmodule

// File: tb/tb_timing_ctrl.sv
// ---------------------------------------------------------------------------
// tb_timing_ctrl
//
// Self-checking bench for timing_ctrl. Directed scenarios walk the ring,
// early end, wait states, halt, single step, mid-instruction reset and
// counter wrap, then a randomized run compares every output each cycle
// against a small behavioural model that tracks the phase as an integer
// index and the mode as a plain integer.
// ---------------------------------------------------------------------------
module tb_timing_ctrl;

    localparam int NP = 8;
    localparam int CW = 8;

    logic          clk = 1'b0;
    logic          rst, start, step, halt, cyc_end, mem_wait;
    logic [NP-1:0] T;
    logic          running, halted, fetch;
    logic [CW-1:0] icount;

    int checks = 0;
    int passes = 0;

    // Reference model: mode 0 idle, 1 run, 2 step, 3 halted.
    int m_mode  = 0;
    int m_phase = 0;
    bit m_pend  = 0;
    int m_count = 0;

    timing_ctrl #(.NPHASE(NP), .CYC_W(CW)) dut (
        .clk(clk), .rst(rst), .start(start), .step(step), .halt(halt),
        .cyc_end(cyc_end), .mem_wait(mem_wait), .T(T), .running(running),
        .halted(halted), .fetch(fetch), .icount(icount)
    );

    always #5 clk = ~clk;

    // Advance the model by one clock using the inputs present at the edge.
    function automatic void model_update();
        bit hnow;
        if (rst) begin
            m_mode = 0; m_phase = 0; m_pend = 0; m_count = 0;
        end else if (m_mode == 0 || m_mode == 3) begin
            if (start) begin m_mode = 1; m_phase = 0; end
            else if (step) begin m_mode = 2; m_phase = 0; end
        end else begin
            hnow = (m_mode == 1) && halt;
            if (hnow) m_pend = 1;
            if (!mem_wait) begin
                if (cyc_end || m_phase == NP - 1) begin
                    m_count = (m_count + 1) % (1 << CW);
                    if (m_mode == 2 || m_pend) begin
                        m_mode = 3; m_pend = 0;
                    end
                    m_phase = 0;
                end else begin
                    m_phase = m_phase + 1;
                end
            end
        end
    endfunction

    function automatic logic [NP-1:0] exp_t();
        logic [NP-1:0] one = 1;
        return (m_mode == 1 || m_mode == 2) ? (one << m_phase) : '0;
    endfunction

    // One clock: edge, model update, then settle before any sampling.
    task automatic tick();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic clear_inputs();
        rst = 0; start = 0; step = 0; halt = 0; cyc_end = 0; mem_wait = 0;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst = 1;
        tick();
        tick();
        rst = 0;
        checks++; if (T !== 8'h00) $display("[TB] FAIL reset_T got %h exp 00", T); else passes++;
        checks++; if (icount !== 8'd0) $display("[TB] FAIL reset_icount got %0d exp 0", icount); else passes++;
        checks++; if (running !== 1'b0) $display("[TB] FAIL reset_running got %b exp 0", running); else passes++;
        checks++; if (halted !== 1'b0) $display("[TB] FAIL reset_halted got %b exp 0", halted); else passes++;
        checks++; if (fetch !== 1'b0) $display("[TB] FAIL reset_fetch got %b exp 0", fetch); else passes++;
    endtask

    task automatic test_ring();
        logic [NP-1:0] e;
        start = 1;
        tick();
        start = 0;
        for (int i = 0; i < NP; i++) begin
            e = 8'h01 << i;
            checks++; if (T !== e) $display("[TB] FAIL ring_T%0d got %h exp %h", i, T, e); else passes++;
            checks++; if (icount !== 8'd0) $display("[TB] FAIL ring_icount%0d got %0d exp 0", i, icount); else passes++;
            checks++; if (fetch !== (i < 2)) $display("[TB] FAIL ring_fetch%0d got %b exp %b", i, fetch, i < 2); else passes++;
            tick();
        end
        checks++; if (T !== 8'h01) $display("[TB] FAIL ring_wrap_T got %h exp 01", T); else passes++;
        checks++; if (icount !== 8'd1) $display("[TB] FAIL ring_wrap_icount got %0d exp 1", icount); else passes++;
    endtask

    task automatic test_early_end();
        tick(); tick(); tick();
        checks++; if (T !== 8'h08) $display("[TB] FAIL early_pre_T got %h exp 08", T); else passes++;
        cyc_end = 1;
        tick();
        cyc_end = 0;
        checks++; if (T !== 8'h01) $display("[TB] FAIL early_T got %h exp 01", T); else passes++;
        checks++; if (icount !== 8'd2) $display("[TB] FAIL early_icount got %0d exp 2", icount); else passes++;
    endtask

    task automatic test_mem_wait();
        tick(); tick();
        checks++; if (T !== 8'h04) $display("[TB] FAIL wait_pre_T got %h exp 04", T); else passes++;
        mem_wait = 1;
        cyc_end  = 1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (T !== 8'h04) $display("[TB] FAIL wait_hold%0d got %h exp 04", i, T); else passes++;
            checks++; if (icount !== 8'd2) $display("[TB] FAIL wait_icount%0d got %0d exp 2", i, icount); else passes++;
        end
        mem_wait = 0;
        cyc_end  = 0;
        tick();
        checks++; if (T !== 8'h08) $display("[TB] FAIL wait_release_T got %h exp 08", T); else passes++;
    endtask

    task automatic test_halt();
        for (int i = 0; i < 5; i++) tick();
        checks++; if (T !== 8'h01) $display("[TB] FAIL halt_pre_T got %h exp 01", T); else passes++;
        tick();
        halt = 1;
        tick();
        halt = 0;
        checks++; if (T !== 8'h04) $display("[TB] FAIL halt_cont_T got %h exp 04", T); else passes++;
        for (int i = 0; i < 5; i++) tick();
        checks++; if (T !== 8'h80) $display("[TB] FAIL halt_last_T got %h exp 80", T); else passes++;
        checks++; if (running !== 1'b1) $display("[TB] FAIL halt_last_running got %b exp 1", running); else passes++;
        tick();
        checks++; if (T !== 8'h00) $display("[TB] FAIL halted_T got %h exp 00", T); else passes++;
        checks++; if (halted !== 1'b1) $display("[TB] FAIL halted_flag got %b exp 1", halted); else passes++;
        checks++; if (running !== 1'b0) $display("[TB] FAIL halted_running got %b exp 0", running); else passes++;
        checks++; if (icount !== 8'd4) $display("[TB] FAIL halted_icount got %0d exp 4", icount); else passes++;
        tick();
        checks++; if (T !== 8'h00) $display("[TB] FAIL halted_stay_T got %h exp 00", T); else passes++;
        start = 1;
        tick();
        start = 0;
        checks++; if (T !== 8'h01) $display("[TB] FAIL restart_T got %h exp 01", T); else passes++;
    endtask

    task automatic test_step();
        logic [NP-1:0] e;
        int budget;
        halt = 1;
        tick();
        halt = 0;
        budget = 0;
        while (halted !== 1'b1 && budget < 20) begin
            tick();
            budget++;
        end
        checks++; if (halted !== 1'b1) $display("[TB] FAIL step_reach_halt got %b exp 1", halted); else passes++;
        checks++; if (icount !== 8'd5) $display("[TB] FAIL step_pre_icount got %0d exp 5", icount); else passes++;
        step = 1;
        tick();
        step = 0;
        for (int i = 0; i < NP; i++) begin
            e = 8'h01 << i;
            checks++; if (T !== e) $display("[TB] FAIL step_T%0d got %h exp %h", i, T, e); else passes++;
            tick();
        end
        checks++; if (halted !== 1'b1) $display("[TB] FAIL step_halted got %b exp 1", halted); else passes++;
        checks++; if (T !== 8'h00) $display("[TB] FAIL step_end_T got %h exp 00", T); else passes++;
        checks++; if (icount !== 8'd6) $display("[TB] FAIL step_icount got %0d exp 6", icount); else passes++;
        start = 1;
        step  = 1;
        tick();
        start = 0;
        step  = 0;
        for (int i = 0; i < NP; i++) tick();
        checks++; if (T !== 8'h01) $display("[TB] FAIL both_T got %h exp 01", T); else passes++;
        checks++; if (running !== 1'b1) $display("[TB] FAIL both_running got %b exp 1", running); else passes++;
        checks++; if (icount !== 8'd7) $display("[TB] FAIL both_icount got %0d exp 7", icount); else passes++;
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 4; i++) tick();
        checks++; if (T !== 8'h10) $display("[TB] FAIL mid_pre_T got %h exp 10", T); else passes++;
        rst = 1;
        tick();
        rst = 0;
        checks++; if (T !== 8'h00) $display("[TB] FAIL mid_T got %h exp 00", T); else passes++;
        checks++; if (icount !== 8'd0) $display("[TB] FAIL mid_icount got %0d exp 0", icount); else passes++;
        checks++; if (running !== 1'b0 || halted !== 1'b0) $display("[TB] FAIL mid_state got %b%b exp 00", running, halted); else passes++;
    endtask

    task automatic test_wrap();
        start = 1;
        tick();
        start = 0;
        cyc_end = 1;
        for (int i = 0; i < 255; i++) tick();
        checks++; if (icount !== 8'hFF) $display("[TB] FAIL wrap_pre got %0d exp 255", icount); else passes++;
        tick();
        cyc_end = 0;
        checks++; if (icount !== 8'h00) $display("[TB] FAIL wrap_zero got %0d exp 0", icount); else passes++;
        checks++; if (T !== 8'h01) $display("[TB] FAIL wrap_T got %h exp 01", T); else passes++;
    endtask

    task automatic test_random();
        logic [NP-1:0] et;
        bit er;
        for (int c = 0; c < 3000; c++) begin
            rst      = ($urandom_range(0, 199) == 0);
            start    = ($urandom_range(0, 7) == 0);
            step     = ($urandom_range(0, 7) == 0);
            halt     = ($urandom_range(0, 15) == 0);
            cyc_end  = ($urandom_range(0, 5) == 0);
            mem_wait = ($urandom_range(0, 4) == 0);
            tick();
            et = exp_t();
            er = (m_mode == 1 || m_mode == 2);
            checks++; if (T !== et) $display("[TB] FAIL rand_T cyc %0d got %h exp %h", c, T, et); else passes++;
            checks++; if (icount !== CW'(m_count)) $display("[TB] FAIL rand_icount cyc %0d got %0d exp %0d", c, icount, m_count); else passes++;
            checks++; if (running !== er) $display("[TB] FAIL rand_running cyc %0d got %b exp %b", c, running, er); else passes++;
            checks++; if (halted !== (m_mode == 3)) $display("[TB] FAIL rand_halted cyc %0d got %b exp %b", c, halted, m_mode == 3); else passes++;
            checks++; if (fetch !== (er && m_phase < 2)) $display("[TB] FAIL rand_fetch cyc %0d got %b exp %b", c, fetch, er && m_phase < 2); else passes++;
        end
        clear_inputs();
    endtask

    initial begin
        $display("[TB] timing_ctrl bench starting");
        test_reset();
        test_ring();
        test_early_end();
        test_mem_wait();
        test_halt();
        test_step();
        test_reset_mid();
        test_wrap();
        test_random();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
